// File: rtl/fetch_queue_unit_pkg.sv
// Shared defaults and types for the instruction-fetch front end (fetch_queue_unit).
package fetch_queue_unit_pkg;

   localparam int          DEFAULT_DEPTH           = 4;
   localparam int          DEFAULT_MAX_OUTSTANDING = 2;
   localparam logic [31:0] DEFAULT_RESET_PC        = 32'h0000_0000;
   localparam int          INSTR_BYTES             = 4;

   typedef logic [31:0] perf_cnt_t;

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Synchronous FIFO holding {pc+4, instr} entries between the fetch front end and decode.
module fetch_queue_unit_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [W-1:0]               head
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the head is forced to zero while empty instead.
   always_ff @(posedge clk) begin
      if (rst && push && !flush) mem[wr_ptr] <= wdata;
   end

   assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC, imem req/gnt/rvalid credit control, decode-side queue.
// Optional build macro FETCH_PERF_EN adds fetch/flush/stall performance counters.
module fetch_queue_unit
   import fetch_queue_unit_pkg::*;
#(
   parameter int            AW              = 32,
   parameter int            DW              = 32,
   parameter int            DEPTH           = DEFAULT_DEPTH,
   parameter int            MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
   parameter logic [AW-1:0] RESET_PC        = AW'(DEFAULT_RESET_PC)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          redirect_i,
   input  logic [AW-1:0] redirect_pc_i,
   output logic          imem_req_o,
   output logic [AW-1:0] imem_addr_o,
   input  logic          imem_gnt_i,
   input  logic          imem_rvalid_i,
   input  logic [DW-1:0] imem_rdata_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] out_instr_o,
   output logic [AW-1:0] out_pc4_o
`ifdef FETCH_PERF_EN
   ,
   output perf_cnt_t     perf_fetch_o,
   output perf_cnt_t     perf_flush_o,
   output perf_cnt_t     perf_stall_o
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW = $clog2(DEPTH + MAX_OUTSTANDING + 1);

   logic [AW-1:0]    pc;
   logic [AW-1:0]    resp_pc;
   logic [AW-1:0]    redirect_base;
   logic [OW-1:0]    outstanding;
   logic [OW-1:0]    drop;
   logic [CW-1:0]    count;
   logic [SW-1:0]    inflight;
   logic [AW+DW-1:0] head;
   logic             fire;
   logic             push;
   logic             pop;

   assign redirect_base = redirect_pc_i & ~AW'(INSTR_BYTES - 1);
   assign inflight      = SW'(count) + SW'(outstanding);

   // Credits count queued plus in-flight words, so an accepted response always has a free slot.
   assign imem_req_o  = rst && !redirect_i && (inflight < SW'(DEPTH))
                        && (outstanding < OW'(MAX_OUTSTANDING));
   assign imem_addr_o = pc;
   assign fire        = imem_req_o && imem_gnt_i;

   assign push = imem_rvalid_i && (drop == '0) && !redirect_i;
   assign pop  = out_valid_o && out_ready_i && !redirect_i;

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc          <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else if (redirect_i) begin
         // Every word still owed by memory belongs to the old path; a response arriving now is discarded.
         pc          <= redirect_base;
         resp_pc     <= redirect_base;
         drop        <= outstanding - OW'(imem_rvalid_i);
         outstanding <= outstanding - OW'(imem_rvalid_i);
      end else begin
         if (fire) pc      <= pc + AW'(INSTR_BYTES);
         if (push) resp_pc <= resp_pc + AW'(INSTR_BYTES);
         if (imem_rvalid_i && (drop != '0)) drop <= drop - 1'b1;
         outstanding <= outstanding + OW'(fire) - OW'(imem_rvalid_i);
      end
   end

   fetch_queue_unit_fifo #(
      .DEPTH (DEPTH),
      .W     (AW + DW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({resp_pc + AW'(INSTR_BYTES), imem_rdata_i}),
      .pop   (pop),
      .flush (redirect_i),
      .count (count),
      .head  (head)
   );

   assign out_valid_o = (count != '0);
   assign out_pc4_o   = head[AW+DW-1:DW];
   assign out_instr_o = head[DW-1:0];

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_fetch_o <= '0;
         perf_flush_o <= '0;
         perf_stall_o <= '0;
      end else begin
         if (push)                       perf_fetch_o <= perf_fetch_o + 1'b1;
         if (redirect_i)                 perf_flush_o <= perf_flush_o + 1'b1;
         if (out_valid_o && !out_ready_i) perf_stall_o <= perf_stall_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: memory model, expected-stream queue and a pop monitor.
module tb_fetch_queue_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_instr_o;
   logic [31:0] out_pc4_o;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] instr;
   } exp_t;

   typedef struct packed {
      logic [31:0] due;
      logic [31:0] addr;
   } pend_t;

   exp_t  exp_q[$];
   pend_t pend[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    n_pops   = 0;
   int    cyc      = 0;
   int    mem_lat  = 1;

   always #5 clk = ~clk;

   fetch_queue_unit dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_instr_o   (out_instr_o),
      .out_pc4_o     (out_pc4_o)
   );

   function automatic logic [31:0] instr_at(input logic [31:0] a);
      return {8'hA5, a[23:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Program order from base: entry i carries pc4 = base+4(i+1) and the word at base+4i.
   task automatic expect_stream(input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 64; i++)
         exp_q.push_back('{pc4: base + 32'((i + 1) * 4), instr: instr_at(base + 32'(i * 4))});
   endtask

   // Instruction memory: in-order responses mem_lat cycles after grant, cleared by reset.
   initial begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      forever begin
         @(negedge clk);
         if (!rst) pend.delete();
         else if (imem_req_o && imem_gnt_i)
            pend.push_back('{due: 32'(cyc + mem_lat), addr: imem_addr_o});
         @(posedge clk);
         cyc++;
         #1;
         if (pend.size() != 0 && pend[0].due <= 32'(cyc)) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = instr_at(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
         end
      end
   end

   // Monitor: every accepted head is compared against the front of the expected stream.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && out_valid_o && out_ready_i && !redirect_i) begin
            n_pops++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL scoreboard: pop of pc4 0x%0h with nothing expected", out_pc4_o);
            end else begin
               e = exp_q.pop_front();
               check("out_pc4", 64'(out_pc4_o), 64'(e.pc4));
               check("out_instr", 64'(out_instr_o), 64'(e.instr));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      int first;
      bit found;

      rst           = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      imem_gnt_i    = 1'b1;
      out_ready_i   = 1'b1;
      step();
      step();
      check("reset_req", 64'(imem_req_o), 64'(0));
      check("reset_valid", 64'(out_valid_o), 64'(0));
      check("reset_instr", 64'(out_instr_o), 64'(0));
      check("reset_pc4", 64'(out_pc4_o), 64'(0));
      check("reset_addr", 64'(imem_addr_o), 64'(0));

      // 1: streaming from reset, first entry two cycles after the first grant, then one per cycle.
      expect_stream(32'h0);
      step();
      rst   = 1'b1;
      first = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid_o) begin
            first = i;
            break;
         end
      end
      check("first_valid_cycle", 64'(first), 64'(2));
      step();
      p0 = n_pops;
      repeat (8) step();
      check("throughput_pops", 64'(n_pops - p0), 64'(8));

      // 2: decode stall fills the queue and stops requests; release resumes at full rate.
      out_ready_i = 1'b0;
      p0 = n_pops;
      repeat (8) step();
      check("full_valid", 64'(out_valid_o), 64'(1));
      check("full_req", 64'(imem_req_o), 64'(0));
      check("stall_pops", 64'(n_pops - p0), 64'(0));
      out_ready_i = 1'b1;
      p0 = n_pops;
      repeat (8) step();
      check("resume_pops", 64'(n_pops - p0), 64'(8));

      // 3: redirect to an unaligned target while two requests are outstanding.
      mem_lat = 3;
      found   = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (pend.size() == 2 && !imem_rvalid_i) begin
            found = 1'b1;
            break;
         end
      end
      check("two_outstanding_seen", 64'(found), 64'(1));
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0103;
      expect_stream(32'h0000_0100);
      p0 = n_pops;
      check("redirect_req", 64'(imem_req_o), 64'(0));
      step();
      redirect_i = 1'b0;
      repeat (12) step();
      check("redirect_progress", 64'((n_pops - p0) >= 2), 64'(1));

      // 4: redirect coinciding with a response and a pop empties the queue next cycle.
      mem_lat = 1;
      repeat (10) step();
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (imem_rvalid_i && out_valid_o) begin
            found = 1'b1;
            break;
         end
         step();
      end
      check("rvalid_pop_seen", 64'(found), 64'(1));
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0400;
      expect_stream(32'h0000_0400);
      step();
      redirect_i = 1'b0;
      check("flush_valid", 64'(out_valid_o), 64'(0));
      repeat (6) step();

      // 5: grant withheld: address holds at the next PC and the queue drains.
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      expect_stream(32'h0000_0200);
      step();
      redirect_i = 1'b0;
      step();
      imem_gnt_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_addr", 64'(imem_addr_o), 64'(32'h0000_0204));
         if (i < 4) step();
      end
      check("drained_valid", 64'(out_valid_o), 64'(0));
      imem_gnt_i = 1'b1;
      repeat (4) step();

      // 6: reset with three queued entries returns to RESET_PC and an empty queue.
      out_ready_i   = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0500;
      expect_stream(32'h0000_0500);
      step();
      redirect_i = 1'b0;
      repeat (4) step();
      check("queued_valid", 64'(out_valid_o), 64'(1));
      check("queued_head_pc4", 64'(out_pc4_o), 64'(32'h0000_0504));
      rst = 1'b0;
      exp_q.delete();
      step();
      rst = 1'b1;
      check("midreset_valid", 64'(out_valid_o), 64'(0));
      check("midreset_addr", 64'(imem_addr_o), 64'(0));
      check("midreset_pc4", 64'(out_pc4_o), 64'(0));
      expect_stream(32'h0);
      out_ready_i = 1'b1;
      p0 = n_pops;
      repeat (10) step();
      check("post_reset_pops", 64'(n_pops - p0), 64'(8));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
